tx_udp: RTL and testbench
=========================

// Module: tx_udp
// PURPOSE
//  UDP transmit framer; the transmit-side counterpart of the UDP receive parser.
//  On tx_start it latches ports and payload length, then emits an 8-byte UDP header
//  (src port, dst port, length, checksum) followed by exactly payload_len payload bytes.
//  Payload is pulled from an upstream byte stream. The byte stream goes to the IPv4 tx layer.
// PARAMETERS
//  OCT      8   byte width in bits; all 16-bit fields are OCT*2 wide
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  tx_start       in   1      1-cycle request; sampled only in IDLE
//  tx_src_port    in   16     source port, latched on accepted tx_start
//  tx_dst_port    in   16     destination port, latched on accepted tx_start
//  tx_payload_len in   16     payload byte count, latched on accepted tx_start
//  pl_valid       in   1      upstream payload byte valid
//  pl_data        in   OCT    upstream payload byte
//  pl_ready       out  1      payload byte consumed this cycle when pl_valid&&pl_ready
//  out_ready      in   1      downstream accepts out_data this cycle
//  out_valid      out  1      out_data valid
//  out_data       out  OCT    UDP datagram byte, network (big-endian) order
//  out_last       out  1      qualifies final byte of datagram
//  tx_busy        out  1      high from accepted start until last byte accepted
//  tx_done        out  1      1-cycle pulse when last byte accepted
//  tx_err         out  1      1-cycle pulse: start rejected (length overflow)
// BEHAVIOUR
//  Reset: state=IDLE, counters 0, out_valid/out_last/pl_ready/tx_busy/tx_done/tx_err=0, out_data=0.
//  Reset mid-datagram aborts at once; no out_last, no tx_done; next start is a fresh datagram.
//  Output register: out_* load only when !out_valid || out_ready (load slot); held stable otherwise.
//  States: IDLE -> HDR -> PAYLOAD -> IDLE.
//  IDLE: tx_start with tx_payload_len<=16'hFFF7 latches inputs, computes udp_len=len+8 (16-bit),
//   sets tx_busy, goes HDR. If len>16'hFFF7: tx_err pulse next cycle, stay IDLE.
//  HDR: one header byte per load slot, hdr_cnt 0..7: src[15:8], src[7:0], dst[15:8], dst[7:0],
//   udp_len[15:8], udp_len[7:0], 8'h00, 8'h00 (checksum disabled, legal for IPv4).
//   First header byte is valid the cycle after tx_start (latency 1).
//   After byte 7 is loaded: goes PAYLOAD if len>0, else byte 7 carries out_last and goes to the done wait.
//  PAYLOAD: pl_ready = (!out_valid || out_ready) && remaining!=0, combinational.
//   On pl_valid&&pl_ready load pl_data, remaining--. The load of the byte that makes remaining
//   reach 0 sets out_last. pl_ready is 0 in IDLE/HDR and after the last byte is taken.
//   pl_valid low creates a bubble: out_valid drops when the held byte is accepted; no stall limit.
//  Completion: when out_valid&&out_ready&&out_last: out_valid=0, tx_busy=0, tx_done=1 (next cycle),
//   state IDLE. A new tx_start is accepted no earlier than the cycle tx_busy is low.
//  tx_start while busy: ignored, no error.
//  Counters: hdr_cnt 3 bits; remaining 16 bits, never wraps below 0.
//  Surplus upstream bytes are never consumed. A new datagram may start the cycle after tx_done.
// TESTING
//  1 src=0x1234 dst=0x0050 len=4 payload AA BB CC DD, out_ready=1 -> bytes
//    12 34 00 50 00 0C 00 00 AA BB CC DD; out_last on DD; tx_done 1 cycle after DD.
//  2 len=0 -> 8 header bytes, length field 00 08, out_last on 8th byte, pl_ready never high.
//  3 len=3, out_ready toggled 1010..., pl_valid random gaps -> stream identical to ideal case,
//    out_data stable while stalled, no byte dropped or duplicated.
//  4 len=16'hFFF8 -> tx_err pulse, tx_busy stays 0, no out_valid; then len=1 succeeds.
//  5 tx_start asserted again mid-payload of len=10 -> ignored; exactly 18 bytes, one tx_done.
//  6 rst during byte 5 of payload -> all outputs reset next cycle; next start len=2 -> clean 10-byte datagram.

Source files
------------

// File: rtl/tx_udp.sv
// UDP transmit framer: 8-byte header (src, dst, length, zero checksum) then payload_len bytes pulled from upstream.
// Latency: first header byte valid 1 cycle after accepted tx_start; output register stalls on !out_ready.
module tx_udp #(
    parameter int OCT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [2*OCT-1:0]   tx_src_port,
    input  logic [2*OCT-1:0]   tx_dst_port,
    input  logic [2*OCT-1:0]   tx_payload_len,
    input  logic               pl_valid,
    input  logic [OCT-1:0]     pl_data,
    output logic               pl_ready,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [OCT-1:0]     out_data,
    output logic               out_last,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               tx_err
);
    localparam int W = 2 * OCT;
    // Largest payload whose length plus the 8-byte header still fits the 16-bit field.
    localparam logic [W-1:0] LEN_MAX = ~W'(8);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_LAST} state_t;

    state_t         state_q, state_d;
    logic [2:0]     hdr_cnt_q, hdr_cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   src_q, src_d;
    logic [W-1:0]   dst_q, dst_d;
    logic [W-1:0]   ulen_q, ulen_d;
    logic           out_valid_q, out_valid_d;
    logic [OCT-1:0] out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           load_slot;
    logic           start_ok;
    logic           start_bad;
    logic           pl_take;
    logic           done_evt;
    logic [OCT-1:0] hdr_byte;

    assign load_slot = !out_valid_q || out_ready;
    assign start_ok  = (state_q == S_IDLE) && tx_start && (tx_payload_len <= LEN_MAX);
    assign start_bad = (state_q == S_IDLE) && tx_start && (tx_payload_len > LEN_MAX);
    assign pl_take   = pl_valid && pl_ready;
    assign done_evt  = out_valid_q && out_ready && out_last_q;

    // Byte 0 is loaded straight from the ports on start, so only bytes 1..7 come from here.
    always_comb begin
        case (hdr_cnt_q)
            3'd1:    hdr_byte = src_q[OCT-1:0];
            3'd2:    hdr_byte = dst_q[W-1:OCT];
            3'd3:    hdr_byte = dst_q[OCT-1:0];
            3'd4:    hdr_byte = ulen_q[W-1:OCT];
            3'd5:    hdr_byte = ulen_q[OCT-1:0];
            default: hdr_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_HDR;
            end
            S_HDR: begin
                if (load_slot && hdr_cnt_q == 3'd7) begin
                    state_d = (rem_q != '0) ? S_PAYLOAD : S_LAST;
                end
            end
            S_PAYLOAD: begin
                if (pl_take && rem_q == W'(1)) state_d = S_LAST;
            end
            S_LAST: begin
                if (done_evt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pl_ready    = (state_q == S_PAYLOAD) && load_slot && (rem_q != '0);
        hdr_cnt_d   = hdr_cnt_q;
        rem_d       = rem_q;
        src_d       = src_q;
        dst_d       = dst_q;
        ulen_d      = ulen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    src_d       = tx_src_port;
                    dst_d       = tx_dst_port;
                    ulen_d      = tx_payload_len + W'(8);
                    rem_d       = tx_payload_len;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = tx_src_port[W-1:OCT];
                    out_last_d  = 1'b0;
                    hdr_cnt_d   = 3'd1;
                end else if (start_bad) begin
                    err_d = 1'b1;
                end
            end
            S_HDR: begin
                if (load_slot) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_byte;
                    out_last_d  = (hdr_cnt_q == 3'd7) && (rem_q == '0);
                    hdr_cnt_d   = hdr_cnt_q + 3'd1;
                end
            end
            S_PAYLOAD: begin
                if (pl_take) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pl_data;
                    out_last_d  = (rem_q == W'(1));
                    rem_d       = rem_q - W'(1);
                end else if (load_slot) begin
                    out_valid_d = 1'b0;
                end
            end
            S_LAST: begin
                if (done_evt) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_q   <= '0;
            rem_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            ulen_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hdr_cnt_q   <= hdr_cnt_d;
            rem_q       <= rem_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            ulen_q      <= ulen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign tx_err    = err_q;

endmodule

// File: tb/tb_tx_udp.sv
// Bench for tx_udp: directed datagram sequence with random payload/gaps, checked against a byte-queue model.
module tb_tx_udp;
    logic        clk;
    logic        rst;
    logic        tx_start;
    logic [15:0] tx_src_port;
    logic [15:0] tx_dst_port;
    logic [15:0] tx_payload_len;
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic        pl_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;

    int checks = 0;
    int errors = 0;

    tx_udp #(.OCT(8)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start),
        .tx_src_port(tx_src_port), .tx_dst_port(tx_dst_port), .tx_payload_len(tx_payload_len),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a datagram is the 8 header bytes followed by the first len upstream bytes.
    task automatic run_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                             input int rmode, input bit gaps, input bit pat,
                             input int dup_at, input int rst_at);
        logic [7:0]  exp_q[$];
        logic [7:0]  up_q[$];
        logic [15:0] ulen;
        logic [7:0]  b;
        logic [7:0]  hold_dat;
        int          got, pl_idx, done_cnt;
        bit          hold, prev_last, pl_seen, finished;
        ulen = len + 16'd8;
        exp_q.push_back(src[15:8]);  exp_q.push_back(src[7:0]);
        exp_q.push_back(dst[15:8]);  exp_q.push_back(dst[7:0]);
        exp_q.push_back(ulen[15:8]); exp_q.push_back(ulen[7:0]);
        exp_q.push_back(8'h00);      exp_q.push_back(8'h00);
        for (int i = 0; i < int'(len) + 3; i++) begin
            b = pat ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
            up_q.push_back(b);
            if (i < int'(len)) exp_q.push_back(b);
        end
        got = 0; pl_idx = 0; done_cnt = 0;
        hold = 1'b0; prev_last = 1'b0; pl_seen = 1'b0; finished = 1'b0;
        hold_dat = 8'h00;

        @(negedge clk);
        tx_src_port = src; tx_dst_port = dst; tx_payload_len = len;
        tx_start = 1'b1; out_ready = 1'b1; pl_valid = 1'b0; pl_data = 8'h00;
        @(posedge clk); #1;
        tx_start = 1'b0;

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
            pl_valid  = (pl_idx < up_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
            pl_data   = pl_valid ? up_q[pl_idx] : 8'h00;
            tx_start  = (cyc == dup_at);
            if (tx_start) begin
                tx_src_port = ~src;
                tx_payload_len = 16'd1;
            end
            #1;
            if (cyc == 0) chk("first_hdr_latency", 32'(out_valid), 32'd1);
            if (hold) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(hold_dat));
            end
            chk("tx_done", 32'(tx_done), 32'(prev_last));
            chk("tx_busy", 32'(tx_busy), 32'(!prev_last));
            if (prev_last) begin
                done_cnt++;
                finished = 1'b1;
            end
            if (rst_at >= 0 && got == rst_at) begin
                rst = 1'b1; tx_start = 1'b0; pl_valid = 1'b0;
                @(posedge clk); #1;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_last", 32'(out_last), 32'd0);
                chk("rst_out_data", 32'(out_data), 32'd0);
                chk("rst_pl_ready", 32'(pl_ready), 32'd0);
                chk("rst_busy_done_err", {29'd0, tx_busy, tx_done, tx_err}, 32'd0);
                rst = 1'b0;
                return;
            end
            if (pl_ready) pl_seen = 1'b1;
            if (out_valid && out_ready && !finished) begin
                if (got < exp_q.size()) begin
                    chk("out_data", 32'(out_data), 32'(exp_q[got]));
                    chk("out_last", 32'(out_last), 32'(got == exp_q.size() - 1));
                end else begin
                    chk("extra_byte", 32'(got), 32'(exp_q.size() - 1));
                end
                got++;
            end
            if (pl_valid && pl_ready) pl_idx++;
            hold      = out_valid && !out_ready;
            hold_dat  = out_data;
            prev_last = out_valid && out_ready && out_last;
        end
        tx_start = 1'b0; pl_valid = 1'b0;
        chk("frame_timeout", 32'(finished), 32'd1);
        chk("byte_count", 32'(got), 32'(exp_q.size()));
        chk("payload_consumed", 32'(pl_idx), 32'(len));
        chk("done_count", 32'(done_cnt), 32'd1);
        if (len == 16'd0) chk("pl_ready_len0", 32'(pl_seen), 32'd0);
        @(negedge clk); #1;
        chk("done_pulse_width", 32'(tx_done), 32'd0);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_src_port = 16'h0; tx_dst_port = 16'h0;
        tx_payload_len = 16'h0; pl_valid = 1'b0; pl_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_pl_ready", 32'(pl_ready), 32'd0);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done_err", {30'd0, tx_done, tx_err}, 32'd0);
        rst = 1'b0;

        // Fixed AA BB CC DD payload, ideal handshake.
        run_frame(16'h1234, 16'h0050, 16'd4, 0, 1'b0, 1'b1, -1, -1);
        // Header-only datagram.
        run_frame(16'hBEEF, 16'h0035, 16'd0, 0, 1'b0, 1'b0, -1, -1);
        // Toggling out_ready with upstream gaps.
        run_frame(16'h0400, 16'h1F90, 16'd3, 1, 1'b1, 1'b0, -1, -1);

        // Oversized length is rejected.
        @(negedge clk);
        tx_payload_len = 16'hFFF8; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        chk("err_pulse", 32'(tx_err), 32'd1);
        chk("err_busy", 32'(tx_busy), 32'd0);
        chk("err_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("err_clear", 32'(tx_err), 32'd0);
        chk("err_valid2", 32'(out_valid), 32'd0);
        run_frame(16'h0001, 16'h0002, 16'd1, 0, 1'b0, 1'b0, -1, -1);

        // Restart attempt mid-payload is ignored.
        run_frame(16'hC0DE, 16'h00A1, 16'd10, 0, 1'b0, 1'b0, 11, -1);
        // Reset while payload byte 5 is in flight, then a clean short datagram.
        run_frame(16'h5555, 16'hAAAA, 16'd8, 0, 1'b0, 1'b0, -1, 12);
        run_frame(16'h7777, 16'h8888, 16'd2, 0, 1'b0, 1'b0, -1, -1);

        for (int k = 0; k < 4; k++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom_range(0, 20)), 2, 1'b1, 1'b0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
